pwm_bank_ctrl: RTL and testbench

Register-programmed controller for the soft core's `pwm_out` bank. It generates all channels from one shared prescaler and period counter. Duty and period values are double-buffered: software writes shadow registers, then requests a commit, and the commit is applied atomically at the next period boundary, so no channel ever emits a torn cycle. It sits on the core's peripheral bus, next to the I2C/UART/SPI blocks, and drives the `pwm_out` pins directly.

---
 rtl/pwm_bank_ctrl_pkg.sv | 13 +
 rtl/pwm_bank_ctrl_if.sv | 11 +
 rtl/pwm_bank_ctrl_timebase.sv | 42 ++++
 rtl/pwm_bank_ctrl.sv | 89 ++++++++
 tb/tb_pwm_bank_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_bank_ctrl_pkg.sv
// Register map and bit positions shared by the PWM bank controller and its bench.
package pwm_bank_pkg;
    localparam logic [6:0] ADDR_DUTY_BASE = 7'h00;
    localparam logic [6:0] ADDR_PERIOD    = 7'h40;
    localparam logic [6:0] ADDR_PRESCALE  = 7'h41;
    localparam logic [6:0] ADDR_CTRL      = 7'h42;
    localparam logic [6:0] ADDR_STATUS    = 7'h43;

    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_COMMIT_BIT    = 1;
    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_CNT_LSB     = 16;
endpackage

// File: rtl/pwm_bank_ctrl_if.sv
// Peripheral register bus: single-cycle write/read strobes, read data one cycle later.
interface pwm_bank_if;
    logic        wr_en;
    logic        rd_en;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output wr_en, rd_en, addr, wdata, input rdata);
    modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/pwm_bank_ctrl_timebase.sv
// Shared prescaler and period counter; boundary flags the tick on which cnt wraps.
module pwm_timebase #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in_clk,
    input  logic             reset_reset_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] prescale,
    input  logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] cnt,
    output logic             boundary
);
    logic [CNT_W-1:0] psc_q, psc_d, cnt_q, cnt_d;
    logic             tick;

    // >= so a shrinking prescale/period wraps on the next tick instead of running away
    always_comb begin
        tick     = enable && (psc_q >= prescale);
        boundary = tick && (cnt_q >= period);
        psc_d    = psc_q + 1'b1;
        cnt_d    = cnt_q;
        if (!enable) begin
            psc_d = '0;
            cnt_d = '0;
        end else if (tick) begin
            psc_d = '0;
            cnt_d = boundary ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            psc_q <= '0;
            cnt_q <= '0;
        end else begin
            psc_q <= psc_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pwm_bank_ctrl.sv
// PWM bank: register file, double-buffered duty/period, commit at period boundary, compares.
module pwm_bank_ctrl
    import pwm_bank_pkg::*;
#(
    parameter int CHANNELS = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk_in_clk,
    input  logic                reset_reset_n,
    pwm_bank_if.slave           bus,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                update_irq
);
    logic [CHANNELS-1:0][CNT_W-1:0] duty_sh_q, duty_act_q;
    logic [CNT_W-1:0]               period_sh_q, period_act_q, prescale_q, cnt;
    logic                           enable_q, pending_q, irq_q;
    logic                           boundary, xfer, wr_ctrl, commit_wr;
    logic [CHANNELS-1:0]            pwm_q, pwm_d;
    logic [31:0]                    rdata_q, rdata_d;

    pwm_timebase #(.CNT_W(CNT_W)) u_timebase (
        .clk_in_clk    (clk_in_clk),
        .reset_reset_n (reset_reset_n),
        .enable        (enable_q),
        .prescale      (prescale_q),
        .period        (period_act_q),
        .cnt           (cnt),
        .boundary      (boundary)
    );

    assign wr_ctrl   = bus.wr_en && (bus.addr == ADDR_CTRL);
    assign commit_wr = wr_ctrl && bus.wdata[CTRL_COMMIT_BIT];
    // Registered pending only: a commit landing on the boundary edge waits a full period
    assign xfer      = pending_q && (boundary || !enable_q);

    always_ff @(posedge clk_in_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            duty_sh_q    <= '0;
            duty_act_q   <= '0;
            period_sh_q  <= '1;
            period_act_q <= '1;
            prescale_q   <= '0;
            enable_q     <= 1'b0;
            pending_q    <= 1'b0;
            irq_q        <= 1'b0;
            pwm_q        <= '0;
            rdata_q      <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                if (bus.wr_en && (bus.addr == ADDR_DUTY_BASE + 7'(i)))
                    duty_sh_q[i] <= bus.wdata[CNT_W-1:0];
            if (bus.wr_en && (bus.addr == ADDR_PERIOD))   period_sh_q <= bus.wdata[CNT_W-1:0];
            if (bus.wr_en && (bus.addr == ADDR_PRESCALE)) prescale_q  <= bus.wdata[CNT_W-1:0];
            if (wr_ctrl) enable_q <= bus.wdata[CTRL_ENABLE_BIT];
            if (xfer) begin
                duty_act_q   <= duty_sh_q;
                period_act_q <= period_sh_q;
            end
            pending_q <= commit_wr || (pending_q && !xfer);
            irq_q     <= xfer;
            pwm_q     <= pwm_d;
            rdata_q   <= bus.rd_en ? rdata_d : '0;
        end
    end

    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (bus.addr == ADDR_DUTY_BASE + 7'(i)) rdata_d[CNT_W-1:0] = duty_sh_q[i];
        case (bus.addr)
            ADDR_PERIOD:   rdata_d[CNT_W-1:0] = period_sh_q;
            ADDR_PRESCALE: rdata_d[CNT_W-1:0] = prescale_q;
            ADDR_CTRL:     rdata_d[CTRL_ENABLE_BIT] = enable_q;
            ADDR_STATUS: begin
                rdata_d[STATUS_PENDING_BIT]        = pending_q;
                rdata_d[STATUS_CNT_LSB +: CNT_W]   = cnt;
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cmp
        assign pwm_d[g] = enable_q && (cnt < duty_act_q[g]);
    end

    assign pwm_out    = pwm_q;
    assign update_irq = irq_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_pwm_bank_ctrl.sv
// Bench for pwm_bank_ctrl: register table, PWM shape table, and commit/disable/reset sequences.
module tb_pwm_bank_ctrl;
    import pwm_bank_pkg::*;
    localparam int CHANNELS = 32;
    localparam int CNT_W    = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_bank_if bus();
    logic [CHANNELS-1:0] pwm;
    logic                irq;

    pwm_bank_ctrl #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
        .clk_in_clk    (clk),
        .reset_reset_n (rst_n),
        .bus           (bus),
        .pwm_out       (pwm),
        .update_irq    (irq)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Read scoreboard: expectations queued at issue, compared when rdata is valid
    logic [31:0] exp_q[$];
    string       nm_q[$];
    logic        rd_seen = 1'b0;
    always @(posedge clk) rd_seen <= bus.rd_en;
    always @(negedge clk) begin : rd_mon
        logic [31:0] e;
        string       n;
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected actual=0x%08h required=no_read", bus.rdata);
            end else begin
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                check(n, bus.rdata, e);
            end
        end
    end

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string n, input logic [6:0] a, input logic [31:0] e);
        exp_q.push_back(e); nm_q.push_back(n);
        @(negedge clk);
        bus.rd_en = 1'b1; bus.addr = a;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic rdwr_chk(input string n, input logic [6:0] a, input logic [31:0] d,
                            input logic [31:0] e);
        exp_q.push_back(e); nm_q.push_back(n);
        @(negedge clk);
        bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    endtask

    // Returns at the negedge where ch0 first shows high; the live cnt is then 1
    task automatic wait_rise(input string n);
        logic prev;
        logic ok;
        ok = 1'b0;
        prev = pwm[0];
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (pwm[0] && !prev) begin ok = 1'b1; break; end
            prev = pwm[0];
        end
        check(n, 32'(ok), 32'd1);
    endtask

    task automatic apply_cfg(input int psc, input int per, input int d0, input int d1, input int d2);
        wr(ADDR_CTRL, 32'h0);
        wr(ADDR_PRESCALE, 32'(psc));
        wr(ADDR_PERIOD, 32'(per));
        wr(7'd0, 32'(d0));
        wr(7'd1, 32'(d1));
        wr(7'd2, 32'(d2));
        wr(ADDR_CTRL, 32'h2);
        @(negedge clk);
        check("cfg_irq", 32'(irq), 32'd1);
    endtask

    typedef struct { logic wr; logic [6:0] a; logic [31:0] d; logic [31:0] e; } reg_vec_t;
    typedef struct { int psc; int per; int d0; int d1; int d2; int h0; int h1; int h2; int len; } pwm_vec_t;
    reg_vec_t rv[12];
    pwm_vec_t pv[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, h1, h2, ic, cnt, first_irq;
        logic prev;
        logic [9:0] pat;

        rv[0]  = '{1'b0, ADDR_PERIOD,   32'h0,       32'h0000FFFF};
        rv[1]  = '{1'b0, ADDR_PRESCALE, 32'h0,       32'h0};
        rv[2]  = '{1'b0, ADDR_CTRL,     32'h0,       32'h0};
        rv[3]  = '{1'b0, ADDR_STATUS,   32'h0,       32'h0};
        rv[4]  = '{1'b1, 7'h05,         32'h1234,    32'h1234};
        rv[5]  = '{1'b1, 7'h1F,         32'hFFFFABCD,32'hABCD};
        rv[6]  = '{1'b1, ADDR_PERIOD,   32'h12345,   32'h2345};
        rv[7]  = '{1'b1, ADDR_PRESCALE, 32'h3,       32'h3};
        rv[8]  = '{1'b1, 7'h20,         32'h55,      32'h0};
        rv[9]  = '{1'b1, 7'h7F,         32'h1,       32'h0};
        rv[10] = '{1'b1, 7'h05,         32'h0,       32'h0};
        rv[11] = '{1'b1, 7'h1F,         32'h0,       32'h0};

        pv[0] = '{0, 9, 3, 0, 10,     3, 0, 10, 10};
        pv[1] = '{1, 9, 3, 0, 10,     6, 0, 20, 20};
        pv[2] = '{0, 4, 5, 1, 4,      5, 1, 4,  5};
        pv[3] = '{2, 3, 2, 3, 'hFFFF, 6, 9, 12, 12};

        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_pwm", 32'(pwm), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (rv[i].wr) wr(rv[i].a, rv[i].d);
            rd_chk($sformatf("reg%0d", i), rv[i].a, rv[i].e);
        end
        rdwr_chk("rw_same_old", ADDR_PRESCALE, 32'h7, 32'h3);
        rd_chk("rw_same_new", ADDR_PRESCALE, 32'h7);

        for (int i = 0; i < 4; i++) begin
            apply_cfg(pv[i].psc, pv[i].per, pv[i].d0, pv[i].d1, pv[i].d2);
            wr(ADDR_CTRL, 32'h1);
            repeat (2 * pv[i].len) @(negedge clk);
            h0 = 0; h1 = 0; h2 = 0; ic = 0;
            for (int k = 0; k < pv[i].len; k++) begin
                @(negedge clk);
                h0 += int'(pwm[0]); h1 += int'(pwm[1]); h2 += int'(pwm[2]); ic += int'(irq);
            end
            check($sformatf("v%0d_hi0", i), 32'(h0), 32'(pv[i].h0));
            check($sformatf("v%0d_hi1", i), 32'(h1), 32'(pv[i].h1));
            check($sformatf("v%0d_hi2", i), 32'(h2), 32'(pv[i].h2));
            check($sformatf("v%0d_irq_once", i), 32'(ic), 32'd0);
            if (pv[i].h0 > 0 && pv[i].h0 < pv[i].len) begin
                wait_rise($sformatf("v%0d_rise", i));
                cnt = 0; prev = 1'b1;
                for (int k = 0; k < 4 * pv[i].len; k++) begin
                    @(negedge clk);
                    cnt++;
                    if (pwm[0] && !prev) break;
                    prev = pwm[0];
                end
                check($sformatf("v%0d_period", i), 32'(cnt), 32'(pv[i].len));
            end
        end

        // Shadow write without commit, then commit mid-period
        apply_cfg(0, 9, 3, 0, 10);
        wr(ADDR_CTRL, 32'h1);
        wait_rise("a_rise0");
        wr(7'd0, 32'd7);
        h0 = 0;
        for (int k = 0; k < 30; k++) begin @(negedge clk); h0 += int'(pwm[0]); end
        check("a_no_commit_hi", 32'(h0), 32'd9);
        rd_chk("a_shadow", 7'd0, 32'd7);
        wait_rise("a_rise1");
        wr(ADDR_CTRL, 32'h3);
        rd_chk("a_pending", ADDR_STATUS, 32'h0004_0001);
        first_irq = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (irq) begin first_irq = k; break; end
        end
        check("a_irq_seen", 32'(first_irq >= 0), 32'd1);
        pat = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) check("a_irq_width", 32'(irq), 32'd0);
            pat = {pat[8:0], pwm[0]};
        end
        check("a_new_duty_pat", 32'(pat), 32'b11_1111_1000);

        // Commit landing on the boundary edge waits one full period
        wait_rise("b_rise");
        repeat (7) @(negedge clk);
        wr(ADDR_CTRL, 32'h3);
        check("b_not_seen", 32'(irq), 32'd0);
        first_irq = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (irq) begin first_irq = k; break; end
        end
        check("b_irq_delay", 32'(first_irq), 32'd10);

        // Disable with commit pending
        wait_rise("c_rise");
        wr(7'd0, 32'd2);
        wr(ADDR_CTRL, 32'h3);
        wr(ADDR_CTRL, 32'h0);
        check("c_irq_early", 32'(irq), 32'd0);
        @(negedge clk);
        check("c_irq", 32'(irq), 32'd1);
        check("c_pwm_off", 32'(pwm), 32'h0);
        @(negedge clk);
        check("c_irq_drop", 32'(irq), 32'd0);
        rd_chk("c_status", ADDR_STATUS, 32'h0);
        rd_chk("c_ctrl", ADDR_CTRL, 32'h0);

        // Reset mid-period with commit pending
        wr(7'd0, 32'd5);
        wr(ADDR_CTRL, 32'h1);
        wait_rise("d_rise");
        wr(ADDR_CTRL, 32'h3);
        check("d_pre_pwm2", 32'(pwm[2]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("d_rst_pwm", 32'(pwm), 32'h0);
        check("d_rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("d_period", ADDR_PERIOD, 32'h0000FFFF);
        rd_chk("d_status", ADDR_STATUS, 32'h0);
        rd_chk("d_duty0", 7'd0, 32'h0);
        ic = 0;
        for (int k = 0; k < 5; k++) begin @(negedge clk); ic += int'(irq); end
        check("d_no_commit", 32'(ic), 32'd0);

        repeat (3) @(negedge clk);
        check("rd_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
